// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer sequencer.
//   CW_DEF / PW_DEF / RW_DEF : default counter, prescale and burst-count widths
//   state_e                  : sequencer state encoding
package pwm_pkg;

  localparam int unsigned CW_DEF = 16;
  localparam int unsigned PW_DEF = 8;
  localparam int unsigned RW_DEF = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StRun    = 3'd2,
    StUpdate = 3'd3,
    StDone   = 3'd4
  } state_e;

endpackage

// File: rtl/pwm_wrap_detect.sv
// Counter wrap detector. Remembers the previous counter value and flags the
// cycle where the live value has just rolled over.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_run          : sequencer is in RUN; detection only happens here
//   i_clr          : forget history (counter is being cleared)
//   i_count_val    : live counter value
//   i_period       : active period
//   i_upnotdown    : active direction (1 = up)
//   o_wrap         : combinational wrap indication for this cycle
module pwm_wrap_detect
  import pwm_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_run,
  input  logic          i_clr,
  input  logic [CW-1:0] i_count_val,
  input  logic [CW-1:0] i_period,
  input  logic          i_upnotdown,
  output logic          o_wrap
);

  logic [CW-1:0] r_prev_val;
  logic          r_prev_valid;
  logic          w_up_wrap;
  logic          w_dn_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_val   <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_prev_val <= i_count_val;
      // History is only trusted once a full RUN cycle has been observed.
      if (i_clr) begin
        r_prev_valid <= 1'b0;
      end else if (i_run) begin
        r_prev_valid <= 1'b1;
      end
    end
  end

  assign w_up_wrap = (r_prev_val == i_period) && (i_count_val == '0);
  assign w_dn_wrap = (r_prev_val == '0) && (i_count_val == i_period);

  // prev != cur keeps a stalled counter (prescaler, or period 0) from re-triggering.
  assign o_wrap = i_run && r_prev_valid && (r_prev_val != i_count_val) &&
                  (i_upnotdown ? w_up_wrap : w_dn_wrap);

endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM counter sequencer. Holds a shadow configuration, commits it to the
// counter only at a wrap (or while idle), and runs continuous or N-period bursts.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_cfg_*             : shadow configuration from the register bank
//   i_cfg_load          : pulse, capture i_cfg_* into the shadow
//   i_start / i_stop    : pulse, begin run / immediate abort
//   i_count_val         : live counter value
//   o_en, o_count_reset : counter enable / synchronous clear
//   o_period, o_prescale, o_upnotdown : active configuration
//   o_busy, o_upd_pending, o_wrap_pulse, o_done, o_cfg_err : status
module pwm_timer_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CW-1:0] i_cfg_period,
  input  logic [PW-1:0] i_cfg_prescale,
  input  logic          i_cfg_upnotdown,
  input  logic [RW-1:0] i_cfg_repeat,
  input  logic          i_cfg_load,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [CW-1:0] i_count_val,
  output logic          o_en,
  output logic          o_count_reset,
  output logic [CW-1:0] o_period,
  output logic [PW-1:0] o_prescale,
  output logic          o_upnotdown,
  output logic          o_busy,
  output logic          o_upd_pending,
  output logic          o_wrap_pulse,
  output logic          o_done,
  output logic          o_cfg_err
);

  state_e        r_state;
  logic [CW-1:0] r_shd_period;
  logic [PW-1:0] r_shd_prescale;
  logic          r_shd_upnotdown;
  logic [RW-1:0] r_wrap_cnt;

  logic          w_wrap;
  logic          w_commit;
  logic          w_burst_end;
  logic [RW-1:0] w_wrap_cnt_inc;

  pwm_wrap_detect #(
    .CW (CW)
  ) u_wrap_detect (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_run       (r_state == StRun),
    .i_clr       ((r_state == StArm) || (r_state == StUpdate)),
    .i_count_val (i_count_val),
    .i_period    (o_period),
    .i_upnotdown (o_upnotdown),
    .o_wrap      (w_wrap)
  );

  assign w_wrap_cnt_inc = r_wrap_cnt + RW'(1);
  assign w_burst_end    = (i_cfg_repeat != '0) && (w_wrap_cnt_inc == i_cfg_repeat);

  // Shadow moves to active while the counter is not running, or in UPDATE.
  always_comb begin
    w_commit = 1'b0;
    if (!i_stop) begin
      unique case (r_state)
        StIdle, StArm: w_commit = o_upd_pending;
        StUpdate:      w_commit = 1'b1;
        default:       w_commit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_shd_period    <= '0;
      r_shd_prescale  <= '0;
      r_shd_upnotdown <= 1'b0;
      r_wrap_cnt      <= '0;
      o_en            <= 1'b0;
      o_count_reset   <= 1'b0;
      o_period        <= '0;
      o_prescale      <= '0;
      o_upnotdown     <= 1'b0;
      o_busy          <= 1'b0;
      o_upd_pending   <= 1'b0;
      o_wrap_pulse    <= 1'b0;
      o_done          <= 1'b0;
      o_cfg_err       <= 1'b0;
    end else begin
      o_count_reset <= 1'b0;
      o_wrap_pulse  <= 1'b0;
      o_done        <= 1'b0;

      if (w_commit) begin
        o_period      <= r_shd_period;
        o_prescale    <= r_shd_prescale;
        o_upnotdown   <= r_shd_upnotdown;
        o_upd_pending <= 1'b0;
      end

      if (i_stop) begin
        r_state       <= StIdle;
        o_en          <= 1'b0;
        o_count_reset <= 1'b1;
        o_busy        <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            o_en <= 1'b0;
            if (i_start) begin
              r_state       <= StArm;
              o_count_reset <= 1'b1;
              o_busy        <= 1'b1;
            end
          end
          StArm: begin
            r_wrap_cnt <= '0;
            r_state    <= StRun;
            o_en       <= 1'b1;
          end
          StRun: begin
            if (w_wrap) begin
              o_wrap_pulse <= 1'b1;
              if (r_wrap_cnt != '1) begin
                r_wrap_cnt <= w_wrap_cnt_inc;
              end
              if (w_burst_end) begin
                r_state       <= StDone;
                o_en          <= 1'b0;
                o_count_reset <= 1'b1;
                o_done        <= 1'b1;
              end else if (o_upd_pending) begin
                // Drop en for a cycle so the counter's prescaler restarts too.
                r_state       <= StUpdate;
                o_en          <= 1'b0;
                o_count_reset <= 1'b1;
              end
            end
          end
          StUpdate: begin
            r_state <= StRun;
            o_en    <= 1'b1;
          end
          StDone: begin
            r_state <= StIdle;
            o_en    <= 1'b0;
            o_busy  <= 1'b0;
          end
          default: begin
            r_state <= StIdle;
            o_en    <= 1'b0;
            o_busy  <= 1'b0;
          end
        endcase
      end

      // A load outranks a same-cycle commit: the new shadow stays pending.
      if (i_cfg_load) begin
        r_shd_period    <= (i_cfg_period == '0) ? CW'(1) : i_cfg_period;
        r_shd_prescale  <= i_cfg_prescale;
        r_shd_upnotdown <= i_cfg_upnotdown;
        o_upd_pending   <= 1'b1;
        o_cfg_err       <= (i_cfg_period == '0);
      end
    end
  end

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Directed bench for pwm_timer_ctrl with a behavioural PWM counter attached.
module tb_pwm_timer_ctrl;

  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;
  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cfg_period = '0;
  logic [PW-1:0] cfg_prescale = '0;
  logic          cfg_upnotdown = 1'b0;
  logic [RW-1:0] cfg_repeat = '0;
  logic          cfg_load = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] cnt;
  logic [PW-1:0] psc;
  logic          en, count_reset, upnotdown, busy, upd_pending, wrap_pulse, done, cfg_err;
  logic [CW-1:0] period;
  logic [PW-1:0] prescale;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int wraps;
  int dones;

  always #5 clk = ~clk;

  pwm_timer_ctrl #(
    .CW (CW),
    .PW (PW),
    .RW (RW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cfg_period    (cfg_period),
    .i_cfg_prescale  (cfg_prescale),
    .i_cfg_upnotdown (cfg_upnotdown),
    .i_cfg_repeat    (cfg_repeat),
    .i_cfg_load      (cfg_load),
    .i_start         (start),
    .i_stop          (stop),
    .i_count_val     (cnt),
    .o_en            (en),
    .o_count_reset   (count_reset),
    .o_period        (period),
    .o_prescale      (prescale),
    .o_upnotdown     (upnotdown),
    .o_busy          (busy),
    .o_upd_pending   (upd_pending),
    .o_wrap_pulse    (wrap_pulse),
    .o_done          (done),
    .o_cfg_err       (cfg_err)
  );

  // Reference PWM counter driven by the sequencer outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      psc <= '0;
    end else if (count_reset) begin
      cnt <= '0;
      psc <= '0;
    end else if (en) begin
      if (psc == prescale) begin
        psc <= '0;
        if (upnotdown) cnt <= (cnt == period) ? '0 : cnt + 1'b1;
        else           cnt <= (cnt == '0) ? period : cnt - 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
    end else begin
      psc <= '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset: every output low while rst_n is held.
    #3;
    chk("reset_outputs", {en, count_reset, period, prescale, upnotdown, busy, upd_pending,
                          wrap_pulse, done, cfg_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: period 4, prescale 0, up, continuous.
    cfg_period = 16'd4; cfg_prescale = 8'd0; cfg_upnotdown = 1'b1; cfg_repeat = '0;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t1_pending_set", 32'(upd_pending), 32'd1);
    chk("t1_period_not_yet", 32'(period), 32'd0);
    tick();
    chk("t1_idle_commit_period", 32'(period), 32'd4);
    chk("t1_idle_commit_pending", 32'(upd_pending), 32'd0);
    chk("t1_upnotdown", 32'(upnotdown), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_arm_count_reset", 32'(count_reset), 32'd1);
    chk("t1_arm_en", 32'(en), 32'd0);
    chk("t1_arm_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_run_en", 32'(en), 32'd1);
    chk("t1_run_cnt0", 32'(cnt), 32'd0);
    for (int i = 5; i <= 15; i++) begin
      tick();
      chk("t1_cnt", 32'(cnt), 32'((i - 4) % 5));
      chk("t1_wrap_pulse", 32'(wrap_pulse), 32'((i == 10) || (i == 15)));
    end

    // 2: reload period 9 while counting; takes effect only after the wrap.
    tick();
    chk("t2_cnt2", 32'(cnt), 32'd2);
    cfg_period = 16'd9; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t2_pending", 32'(upd_pending), 32'd1);
    chk("t2_period_held", 32'(period), 32'd4);
    tick();
    tick();
    chk("t2_cnt_wrapped", 32'(cnt), 32'd0);
    tick();
    chk("t2_upd_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("t2_upd_en", 32'(en), 32'd0);
    chk("t2_upd_count_reset", 32'(count_reset), 32'd1);
    chk("t2_upd_period_old", 32'(period), 32'd4);
    tick();
    chk("t2_new_period", 32'(period), 32'd9);
    chk("t2_run_en", 32'(en), 32'd1);
    chk("t2_pending_clr", 32'(upd_pending), 32'd0);
    chk("t2_cnt_cleared", 32'(cnt), 32'd0);
    repeat (9) tick();
    chk("t2_cnt9", 32'(cnt), 32'd9);
    tick();
    chk("t2_cnt_back0", 32'(cnt), 32'd0);
    tick();
    chk("t2_wrap9", 32'(wrap_pulse), 32'd1);

    // 4: stop at count 3, then start+stop together in IDLE.
    tick();
    tick();
    chk("t4_cnt3", 32'(cnt), 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stop_busy", 32'(busy), 32'd0);
    chk("t4_stop_en", 32'(en), 32'd0);
    chk("t4_stop_count_reset", 32'(count_reset), 32'd1);
    chk("t4_stop_no_done", 32'(done), 32'd0);
    tick();
    chk("t4_count_reset_1cyc", 32'(count_reset), 32'd0);
    chk("t4_cnt_cleared", 32'(cnt), 32'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t4_ss_busy", 32'(busy), 32'd0);
    chk("t4_ss_count_reset", 32'(count_reset), 32'd1);
    chk("t4_ss_en", 32'(en), 32'd0);
    tick();
    chk("t4_ss_idle", {30'd0, busy, count_reset}, 32'd0);

    // 3: burst of 3 periods, period 2, counting down.
    cfg_period = 16'd2; cfg_upnotdown = 1'b0; cfg_repeat = 16'd3; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
    chk("t3_period", 32'(period), 32'd2);
    chk("t3_down", 32'(upnotdown), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t3_run_en", 32'(en), 32'd1);
    wraps = 0;
    dones = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      wraps += int'(wrap_pulse);
      dones += int'(done);
      if (j == 8) begin
        chk("t3_done_pulse", 32'(done), 32'd1);
        chk("t3_done_en", 32'(en), 32'd0);
        chk("t3_done_count_reset", 32'(count_reset), 32'd1);
      end
      if (j == 9) begin
        chk("t3_busy_fall", 32'(busy), 32'd0);
        chk("t3_done_1cyc", 32'(done), 32'd0);
        chk("t3_idle_en", 32'(en), 32'd0);
      end
    end
    chk("t3_wrap_count", 32'(wraps), 32'd3);
    chk("t3_done_count", 32'(dones), 32'd1);
    cfg_repeat = '0;

    // 5: period 0 flags cfg_err and is stored as 1; valid load clears it.
    cfg_period = 16'd0; cfg_upnotdown = 1'b1; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t5_cfg_err_set", 32'(cfg_err), 32'd1);
    tick();
    chk("t5_period_one", 32'(period), 32'd1);
    chk("t5_cfg_err_sticky", 32'(cfg_err), 32'd1);
    cfg_period = 16'd5; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t5_cfg_err_clr", 32'(cfg_err), 32'd0);
    tick();
    chk("t5_period5", 32'(period), 32'd5);

    // 6: asynchronous reset mid-run with an update pending.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cfg_period = 16'd7; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t6_pending", 32'(upd_pending), 32'd1);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_en", 32'(en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_outputs", {en, count_reset, period, prescale, upnotdown, busy, upd_pending,
                             wrap_pulse, done, cfg_err}, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_pending_after", 32'(upd_pending), 32'd0);
    chk("t6_busy_after", 32'(busy), 32'd0);
    chk("t6_period_after", 32'(period), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
